lookup_arbiter: RTL

Round-robin scheduler that shares the single multi-cycle dictionary lookup engine (the `wordlist` question/ready/valid/picked interface) among up to four requesters, e.g. guess validation, solution picking and a hint generator. It captures one requester's 25-bit word and drives it onto the engine's question bus. It waits out the engine's settle time and result, then returns hit/number/picked to the owning requester as a one-cycle response pulse. It sits between `control`-level game logic and the wordlist instance.

---
 rtl/lookup_arbiter.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/lookup_arbiter.sv
// lookup_arbiter
//
// Round-robin scheduler that shares one multi-cycle dictionary lookup engine
// among NREQ requesters. A grant latches the requester's 25-bit word (five 5-bit
// letters), drives it onto the engine question bus, waits out the engine settle
// time, then waits for eng_ready. The result goes back to the owning requester
// as a one-cycle resp_valid pulse. A word with any letter above 25 is rejected
// without touching the engine.
//
// Optional feature macro: LOOKUP_TIMEOUT_EN
//   When defined, a watchdog ends a WAIT that lasts TIMEOUT cycles and reports
//   resp_timeout=1. When undefined, no counter is built and resp_timeout is 0.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   req_valid[NREQ]    : request pending, held until accepted
//   req_word[25*NREQ]  : requester k word at [25k +: 25]
//   req_ready[NREQ]    : one-hot accept pulse (combinational), word captured on it
//   resp_valid[NREQ]   : one-hot one-cycle result pulse to the owner
//   resp_hit           : word found in dictionary
//   resp_num[12]       : engine index, 12'hFFF on miss, reject or timeout
//   resp_picked[25]    : engine picked word, registered
//   resp_timeout       : result produced by the watchdog
//   busy               : arbiter not idle
//   owner[2]           : current or last granted requester
//   eng_question[25]   : engine question bus
//   eng_ready          : engine result settled
//   eng_valid          : engine word valid (hit)
//   eng_picked[25]     : engine picked word
//   eng_picked_num[12] : engine index

module lookup_arbiter #(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [25*NREQ-1:0]   req_word,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic                 resp_hit,
    output logic [11:0]          resp_num,
    output logic [24:0]          resp_picked,
    output logic                 resp_timeout,
    output logic                 busy,
    output logic [1:0]           owner,
    output logic [24:0]          eng_question,
    input  logic                 eng_ready,
    input  logic                 eng_valid,
    input  logic [24:0]          eng_picked,
    input  logic [11:0]          eng_picked_num
);

    // Elaboration-time parameter sanity checks.
    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
        $error("lookup_arbiter: NREQ must be in 2..4");
    end
    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("lookup_arbiter: SETTLE_CYC must be at least 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("lookup_arbiter: TIMEOUT must be at least 1");
    end

    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [11:0] NumNone  = 12'hFFF;
    localparam logic [24:0] WordNone = 25'h1FFFFFF;

    typedef enum logic [1:0] {StIdle, StSettle, StWait, StDone} state_e;

    state_e           state;
    logic [1:0]       rr_ptr;
    logic [SCW-1:0]   settle_cnt;

    logic [3:0]       valid_pad;
    logic [2:0]       scan_pos;
    logic             grant_any;
    logic [1:0]       grant_idx;
    logic [24:0]      grant_word;
    logic             grant_bad;

    // A letter outside 0..25 (including the blank code 5'b11111) is malformed.
    function automatic logic word_bad(input logic [24:0] w);
        logic bad;
        bad = 1'b0;
        for (int l = 0; l < 5; l++) begin
            if (w[5*l +: 5] > 5'd25) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        for (int k = 0; k < NREQ; k++) begin
            v[k] = (idx == 2'(k));
        end
        return v;
    endfunction

    // Padding to four bits lets a 2-bit index select without width games.
    assign valid_pad = 4'(req_valid);

    // Search upward from rr_ptr, wrapping at NREQ. rr_ptr < NREQ always, so
    // a single subtraction is enough to wrap.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        scan_pos  = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            scan_pos = {1'b0, rr_ptr} + 3'(i);
            if (scan_pos >= 3'(NREQ)) begin
                scan_pos = scan_pos - 3'(NREQ);
            end
            if (!grant_any && valid_pad[scan_pos[1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan_pos[1:0];
            end
        end
    end

    always_comb begin
        grant_word = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == 2'(k)) begin
                grant_word = req_word[25*k +: 25];
            end
        end
    end

    assign grant_bad = word_bad(grant_word);

    // Accept is combinational so the word is captured on the same edge.
    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_ready[k] = (state == StIdle) && !rst && grant_any && (grant_idx == 2'(k));
        end
    end

    assign busy = (state != StIdle);

`ifdef LOOKUP_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] wait_cnt;
`else
    assign resp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            rr_ptr       <= 2'd0;
            owner        <= 2'd0;
            settle_cnt   <= '0;
            resp_valid   <= '0;
            resp_hit     <= 1'b0;
            resp_num     <= NumNone;
            resp_picked  <= WordNone;
            eng_question <= WordNone;
`ifdef LOOKUP_TIMEOUT_EN
            wait_cnt     <= '0;
            resp_timeout <= 1'b0;
`endif
        end else begin
            // resp_valid is only ever high in the DONE cycle.
            resp_valid <= '0;
            unique case (state)
                StIdle: begin
                    if (grant_any) begin
                        owner  <= grant_idx;
                        rr_ptr <= (grant_idx == 2'(NREQ - 1)) ? 2'd0 : grant_idx + 2'd1;
                        if (grant_bad) begin
                            // Reject straight to DONE; the engine never sees the word.
                            state       <= StDone;
                            resp_valid  <= onehot(grant_idx);
                            resp_hit    <= 1'b0;
                            resp_num    <= NumNone;
                            resp_picked <= WordNone;
`ifdef LOOKUP_TIMEOUT_EN
                            resp_timeout <= 1'b0;
`endif
                        end else begin
                            state        <= StSettle;
                            eng_question <= grant_word;
                            settle_cnt   <= '0;
                        end
                    end
                end
                StSettle: begin
                    // eng_ready may still reflect the previous question here.
                    if (settle_cnt == SCW'(SETTLE_CYC - 1)) begin
                        state <= StWait;
`ifdef LOOKUP_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end else begin
                        settle_cnt <= settle_cnt + SCW'(1);
                    end
                end
                StWait: begin
                    if (eng_ready) begin
                        state       <= StDone;
                        resp_valid  <= onehot(owner);
                        resp_hit    <= eng_valid;
                        resp_num    <= eng_valid ? eng_picked_num : NumNone;
                        resp_picked <= eng_picked;
`ifdef LOOKUP_TIMEOUT_EN
                        resp_timeout <= 1'b0;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        state        <= StDone;
                        resp_valid   <= onehot(owner);
                        resp_hit     <= 1'b0;
                        resp_num     <= NumNone;
                        resp_picked  <= WordNone;
                        resp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
`endif
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
